// File: rtl/ripple_carry_add_sub.sv
// ripple_carry_add_sub
//
// Ripple-carry adder/subtractor with a registered {Z,C,N,V} flag register.
// It is the arithmetic core for PC updates and the branch-compare path.
//
// Ports:
//   clk        in   1      rising-edge clock
//   rst        in   1      synchronous active-high reset (clears flags)
//   Cin        in   1      0 = add (A + B), 1 = subtract (A + ~B + 1)
//   A, B       in   WIDTH  operands
//   flag_en    in   1      capture flags of the current inputs at next edge
//   S          out  WIDTH  sum/difference, modulo 2^WIDTH
//   Cout       out  1      carry out of bit WIDTH-1
//   ZCNVFlags  out  4      registered flags, bit 3 = Z, 2 = C, 1 = N, 0 = V
//
// Build option:
//   RCA_OUTPUT_REG_EN  when defined, S and Cout are registered every cycle
//                      and cleared by rst. Flags are always taken from the
//                      pre-register result, so they stay aligned with S.
//
// No handshake: inputs are consumed every cycle; flag_en is a plain
// capture strobe with no back-pressure.

module ripple_carry_add_sub #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Cin,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             flag_en,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic [3:0]       ZCNVFlags
);

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] sum;
    logic             flag_z;
    logic             flag_c;
    logic             flag_n;
    logic             flag_v;

    // Full-adder chain, bit 0 to bit WIDTH-1. Inverting B with Cin and
    // feeding Cin in as carry 0 turns the adder into A + ~B + 1.
    always_comb begin
        carry    = '0;
        b_eff    = '0;
        sum      = '0;
        carry[0] = Cin;
        for (int i = 0; i < WIDTH; i++) begin
            b_eff[i]   = B[i] ^ Cin;
            sum[i]     = A[i] ^ b_eff[i] ^ carry[i];
            carry[i+1] = (A[i] & b_eff[i]) | (carry[i] & (A[i] ^ b_eff[i]));
        end
    end

    // For subtract the raw carry is the inverse of a borrow, so XOR with
    // Cin makes C mean "carry" on add and "borrow" (A < B unsigned) on sub.
    assign flag_z = (sum == '0);
    assign flag_c = carry[WIDTH] ^ Cin;
    assign flag_n = sum[WIDTH-1];
    assign flag_v = carry[WIDTH] ^ carry[WIDTH-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            ZCNVFlags <= 4'b0000;
        end else if (flag_en) begin
            ZCNVFlags <= {flag_z, flag_c, flag_n, flag_v};
        end
    end

`ifdef RCA_OUTPUT_REG_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            S    <= '0;
            Cout <= 1'b0;
        end else begin
            S    <= sum;
            Cout <= carry[WIDTH];
        end
    end
`else
    assign S    = sum;
    assign Cout = carry[WIDTH];
`endif

endmodule

// File: tb/tb_ripple_carry_add_sub.sv
// tb_ripple_carry_add_sub
//
// Directed bench for ripple_carry_add_sub (WIDTH = 32). Each step drives
// operands on the falling edge, checks S/Cout (combinationally, or after the
// next edge when RCA_OUTPUT_REG_EN is defined) and checks the flag register
// one edge later against a hand-computed value held in an expected queue.

module tb_ripple_carry_add_sub;

    localparam int W = 32;

    logic         clk;
    logic         rst;
    logic         cin;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         flag_en;
    logic [W-1:0] s;
    logic         cout;
    logic [3:0]   zcnv;

    int n_assert;
    int n_fail;

    logic [W+4:0] exp_q[$];  // {S, Cout, ZCNV} per step

    ripple_carry_add_sub #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .Cin       (cin),
        .A         (a),
        .B         (b),
        .flag_en   (flag_en),
        .S         (s),
        .Cout      (cout),
        .ZCNVFlags (zcnv)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one vector and queue its expectation.
    task automatic drive(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vcin,
                         input logic ven, input logic vrst,
                         input logic [W-1:0] es, input logic ec, input logic [3:0] ef);
        @(negedge clk);
        a       = va;
        b       = vb;
        cin     = vcin;
        flag_en = ven;
        rst     = vrst;
        exp_q.push_back({es, ec, ef});
    endtask

    // Check the oldest queued expectation across the next rising edge.
    task automatic check_step(input string tag);
        logic [W+4:0] e;
        e = exp_q.pop_front();
`ifndef RCA_OUTPUT_REG_EN
        #1;
        check({tag, ".S"}, 64'(s), 64'(e[W+4:5]));
        check({tag, ".Cout"}, 64'(cout), 64'(e[4]));
`endif
        @(posedge clk);
        #1;
`ifdef RCA_OUTPUT_REG_EN
        check({tag, ".S"}, 64'(s), 64'(e[W+4:5]));
        check({tag, ".Cout"}, 64'(cout), 64'(e[4]));
`endif
        check({tag, ".flags"}, 64'(zcnv), 64'(e[3:0]));
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst      = 1'b1;
        a        = '0;
        b        = '0;
        cin      = 1'b0;
        flag_en  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset.flags", 64'(zcnv), 64'(4'b0000));
`ifdef RCA_OUTPUT_REG_EN
        check("reset.S", 64'(s), 64'(0));
        check("reset.Cout", 64'(cout), 64'(0));
`endif

        drive(32'd5, 32'd3, 1'b0, 1'b1, 1'b0, 32'd8, 1'b0, 4'b0000);
        check_step("add_5_3");

        drive(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 4'b1100);
        check_step("add_wrap");

        drive(32'd3, 32'd5, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 4'b0110);
        check_step("sub_3_5");

        drive(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b1, 1'b0, 32'h8000_0000, 1'b0, 4'b0011);
        check_step("add_ovf");

        // -1 - 1: unsigned A > B (no borrow), signed A < B (N^V = 1)
        drive(32'hFFFF_FFFF, 32'd1, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b1, 4'b0010);
        check_step("sub_neg1_1");

        // most-negative - 1: signed overflow on subtract
        drive(32'h8000_0000, 32'd1, 1'b1, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1, 4'b0001);
        check_step("sub_ovf");

        drive(32'h1234, 32'h1234, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 4'b1000);
        check_step("sub_equal");

        // flag_en low: sum tracks inputs, flags hold 1000
        drive(32'd3, 32'd5, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFE, 1'b0, 4'b1000);
        check_step("hold_1");
        drive(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 4'b1000);
        check_step("hold_2");

        // reset together with flag_en: flags clear; combinational S keeps tracking
`ifdef RCA_OUTPUT_REG_EN
        drive(32'd5, 32'd3, 1'b0, 1'b1, 1'b1, 32'd0, 1'b0, 4'b0000);
`else
        drive(32'd5, 32'd3, 1'b0, 1'b1, 1'b1, 32'd8, 1'b0, 4'b0000);
`endif
        check_step("rst_with_en");

        // recapture after reset released
        drive(32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 4'b1000);
        check_step("add_zero");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    // Overall time bound so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: observed no completion expected completion");
        $fatal(1, "timeout");
    end

endmodule
